// File: rtl/parity_frame_pkg.sv
// ---------------------------------------------------------------------------
// parity_frame_pkg
//   Shared definitions for the parity frame controller.
//   - state_t    : FSM state encoding (S_IDLE, S_DATA, S_PARITY, S_DONE)
//   - exp_parity : parity bit expected after the data bits, given the running
//                  XOR of the data bits and the odd/even selection
// ---------------------------------------------------------------------------
package parity_frame_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Even parity: the parity bit equals the XOR of the data bits.
  // Odd parity: the same value inverted.
  function automatic logic exp_parity(input logic par, input logic odd);
    return par ^ odd;
  endfunction

endpackage

// File: rtl/parity_frame_ctrl_parity_acc.sv
// ---------------------------------------------------------------------------
// parity_acc
//   1-bit running parity register.
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  synchronous, active-high; clears the register
//     clr    in  synchronous clear (start of a new frame)
//     en     in  fold bit_in into the running parity this cycle
//     bit_in in  serial bit
//     par    out running XOR of all enabled bits since the last clear
//   clr has priority over en.
// ---------------------------------------------------------------------------
module parity_acc (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic par
);

  logic par_q, par_d;

  // NOTE: combinational blocks assign a default to every output first so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    par_d = par_q;
    if (clr) begin
      par_d = 1'b0;
    end else if (en) begin
      par_d = par_q ^ bit_in;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign par = par_q;

endmodule

// File: rtl/parity_frame_ctrl.sv
// ---------------------------------------------------------------------------
// parity_frame_ctrl
//   Sequences a serial bitstream into frames of DATA_BITS data bits (LSB
//   first) followed by one parity bit, checks the parity and reports the
//   result of each completed frame.
//
//   Parameters:
//     DATA_BITS  data bits per frame (>= 2)
//     ODD_PARITY 0 = even parity, 1 = odd parity
//     ERR_CNT_W  width of the saturating parity error counter
//
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   synchronous, active-high
//     start      in   begin a frame (honoured only in IDLE)
//     abort      in   drop the current frame, back to IDLE
//     bit_valid  in   bit_in is valid this cycle
//     bit_in     in   serial bit
//     busy       out  high while in DATA or PARITY
//     frame_done out  one-cycle pulse when a frame completes
//     parity_err out  parity mismatch of the last completed frame
//     data_out   out  data of the last completed frame
//     err_count  out  saturating parity error count (PARITY_ERR_CNT_EN only)
//
//   Build option: define PARITY_ERR_CNT_EN to add the err_count port and its
//   counter. Without it the port and counter are absent.
//
//   All outputs are registered. Each is computed from the next state, so
//   busy and frame_done line up with the state the FSM is actually in.
// ---------------------------------------------------------------------------
module parity_frame_ctrl
  import parity_frame_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 parity_err,
  output logic [DATA_BITS-1:0] data_out
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  localparam int               CNT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS - 1);
  localparam logic             ODD_BIT  = (ODD_PARITY != 0);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 parity_err_q, parity_err_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 par_clr, par_en, par;
  logic                 par_mismatch;

  parity_acc u_parity_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (par_clr),
    .en    (par_en),
    .bit_in(bit_in),
    .par   (par)
  );

  // Only meaningful while in PARITY with bit_valid high.
  assign par_mismatch = (bit_in != exp_parity(par, ODD_BIT));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;
    par_clr      = 1'b0;
    par_en       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // abort together with start keeps the FSM idle.
        if (start && !abort) begin
          state_d = S_DATA;
          cnt_d   = '0;
          sr_d    = '0;
          par_clr = 1'b1;
        end
      end
      S_DATA: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_valid) begin
          sr_d   = {bit_in, sr_q[DATA_BITS-1:1]};
          par_en = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_valid) begin
          state_d      = S_DONE;
          data_out_d   = sr_q;
          parity_err_d = par_mismatch;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d       = (state_d == S_DATA) || (state_d == S_PARITY);
    frame_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sr_q         <= '0;
      data_out_q   <= '0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      data_out_q   <= data_out_d;
      parity_err_q <= parity_err_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign parity_err = parity_err_q;
  assign data_out   = data_out_q;

`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // Counts on the same edge that loads parity_err, so the new count is
  // visible in the frame_done cycle of the frame that caused it.
  always_comb begin
    err_count_d = err_count_q;
    if ((state_q == S_PARITY) && !abort && bit_valid && par_mismatch &&
        (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_ctrl
//   Directed bench for parity_frame_ctrl. Two instances share all inputs:
//   dut (even parity) and dut_odd (odd parity), both DATA_BITS=8 and
//   ERR_CNT_W=2. Inputs change 1 ns after a rising edge; outputs are
//   sampled 1 ns after the edge that updates them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_parity_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, abort, bit_valid, bit_in;
  logic       busy, frame_done, parity_err;
  logic [7:0] data_out;
  logic       busy_o, frame_done_o, parity_err_o;
  logic [7:0] data_out_o;
`ifdef PARITY_ERR_CNT_EN
  logic [1:0] err_count, err_count_o;
`endif

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int done_ref;

  always #5 clk = ~clk;

  parity_frame_ctrl #(.DATA_BITS(8), .ODD_PARITY(0), .ERR_CNT_W(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .busy(busy), .frame_done(frame_done), .parity_err(parity_err),
    .data_out(data_out)
`ifdef PARITY_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  parity_frame_ctrl #(.DATA_BITS(8), .ODD_PARITY(1), .ERR_CNT_W(2)) dut_odd (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .busy(busy_o), .frame_done(frame_done_o), .parity_err(parity_err_o),
    .data_out(data_out_o)
`ifdef PARITY_ERR_CNT_EN
    , .err_count(err_count_o)
`endif
  );

  // Counts frame_done pulses of the even-parity instance.
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, take the edge, return 1 ns after it.
  task automatic step(input logic s, input logic a, input logic v,
                      input logic b);
    start = s; abort = a; bit_valid = v; bit_in = b;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] d, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b1, d[i]);
      repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Full frame; returns in the frame_done cycle.
  task automatic send_frame(input logic [7:0] d, input logic p, input int gap);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(d, 8, gap);
    step(1'b0, 1'b0, 1'b1, p);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_data_out", data_out, 0);
`ifdef PARITY_ERR_CNT_EN
    check("rst_err_count", err_count, 0);
`endif
    reset = 1'b0;

    // Bits in IDLE are ignored
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("idle_bits_busy", busy, 0);

    // 1. Good frame 0xA5, parity 0
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_busy_after_start", busy, 1);
    send_bits(8'hA5, 8, 0);
    check("t1_busy_in_parity", busy, 1);
    check("t1_no_early_done", frame_done, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_frame_done", frame_done, 1);
    check("t1_busy_done", busy, 0);
    check("t1_data_out", data_out, 8'hA5);
    check("t1_parity_err", parity_err, 0);
    check("t1_odd_parity_err", parity_err_o, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_done_pulse_end", frame_done, 0);
    check("t1_done_count", done_cnt, 1);

    // 2. Bad parity; start in DONE must be ignored
    send_frame(8'hA5, 1'b1, 0);
    check("t2_frame_done", frame_done, 1);
    check("t2_data_out", data_out, 8'hA5);
    check("t2_parity_err", parity_err, 1);
    check("t2_odd_parity_err", parity_err_o, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_start_in_done_busy", busy, 0);
    check("t2_done_pulse_end", frame_done, 0);

    // 3. Gapped 0x3C, parity 0
    done_ref = done_cnt;
    send_frame(8'h3C, 1'b0, 2);
    check("t3_frame_done", frame_done, 1);
    check("t3_data_out", data_out, 8'h3C);
    check("t3_parity_err", parity_err, 0);
    check("t3_odd_parity_err", parity_err_o, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_one_pulse", done_cnt, done_ref + 1);

    // 4. Abort after 3 bits, then abort+start in IDLE, then 0x01 parity 1
    done_ref = done_cnt;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(8'hFF, 3, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("t4_abort_busy", busy, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_abort_no_done", done_cnt, done_ref);
    check("t4_abort_keeps_data", data_out, 8'h3C);
    check("t4_abort_keeps_err", parity_err, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t4_abort_start_idle", busy, 0);
    send_frame(8'h01, 1'b1, 0);
    check("t4_frame_done", frame_done, 1);
    check("t4_data_out", data_out, 8'h01);
    check("t4_parity_err", parity_err, 0);
    check("t4_odd_parity_err", parity_err_o, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // 5. Reset after 5 bits; then 0x00 with a stray start mid-frame
    done_ref = done_cnt;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(8'hFF, 5, 0);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_reset_busy", busy, 0);
    check("t5_reset_data_out", data_out, 0);
    check("t5_reset_parity_err", parity_err, 0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_reset_no_done", done_cnt, done_ref);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(8'h00, 4, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);   // start while busy, with a data bit
    check("t5_start_busy_ignored", busy, 1);
    send_bits(8'h00, 3, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("t5_frame_done", frame_done, 1);
    check("t5_data_out", data_out_o, 8'h00);
    check("t5_odd_parity_err", parity_err_o, 0);
    check("t5_even_parity_err", parity_err, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // 6. Five bad frames then a good one; counter saturates at 3
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_frame(8'hA5, 1'b1, 0);
      check($sformatf("t6_bad%0d_parity_err", k), parity_err, 1);
`ifdef PARITY_ERR_CNT_EN
      check($sformatf("t6_bad%0d_err_count", k), err_count,
            (k < 3) ? (k + 1) : 3);
`endif
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    send_frame(8'hA5, 1'b0, 0);
    check("t6_good_parity_err", parity_err, 0);
`ifdef PARITY_ERR_CNT_EN
    check("t6_good_err_count", err_count, 3);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
